// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package muldiv_pkg;
  localparam int XLEN_DEF = 32;

  localparam logic [2:0] FN_MUL    = 3'b000;
  localparam logic [2:0] FN_MULH   = 3'b001;
  localparam logic [2:0] FN_MULHSU = 3'b010;
  localparam logic [2:0] FN_MULHU  = 3'b011;
  localparam logic [2:0] FN_DIV    = 3'b100;
  localparam logic [2:0] FN_DIVU   = 3'b101;
  localparam logic [2:0] FN_REM    = 3'b110;
  localparam logic [2:0] FN_REMU   = 3'b111;

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIX, ST_DONE} state_t;
endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the core (master) and the mul/div unit (slave).
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic            wr_en;
  logic [4:0]      rd_out;
  logic [XLEN-1:0] result;

  modport master (output start, funct3, op_a, op_b, rd_in,
                  input  busy, done, wr_en, rd_out, result);
  modport slave  (input  start, funct3, op_a, op_b, rd_in,
                  output busy, done, wr_en, rd_out, result);
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] m_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);
  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  always_comb begin
    sum    = {1'b0, hi_i} + (lo_i[0] ? {1'b0, m_i} : '0);
    rem_sh = {hi_i, lo_i[XLEN-1]};
    diff   = rem_sh - {1'b0, m_i};
    hi_o   = sum[XLEN:1];
    lo_o   = {sum[0], lo_i[XLEN-1:1]};
    if (is_div_i) begin
      // A clear sign bit means the trial subtraction fits: keep it and shift in a 1.
      if (!diff[XLEN]) begin
        hi_o = diff[XLEN-1:0];
        lo_o = {lo_i[XLEN-2:0], 1'b1};
      end else begin
        hi_o = rem_sh[XLEN-1:0];
        lo_o = {lo_i[XLEN-2:0], 1'b0};
      end
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit driving the register-file write port.
// Optional MULDIV_EARLY_OUT_EN skips iteration for zero multiplies and divide-by-zero.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);
  localparam int CW = $clog2(XLEN);

  state_t            state_q;
  logic [CW-1:0]     count_q;
  logic [2:0]        fn_q;
  logic [4:0]        rd_q;
  logic              neg_a_q, neg_b_q;
  logic [XLEN-1:0]   m_q, hi_q, lo_q;
  logic [XLEN-1:0]   result_q;
  logic              busy_q, done_q, wr_en_q;

  logic              signed_a_d, signed_b_d, neg_a_d, neg_b_d;
  logic [XLEN-1:0]   a_mag_d, b_mag_d;
  logic [XLEN-1:0]   hi_d, lo_d, res_d;
  logic [2*XLEN-1:0] prod_d;

  function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_p(input logic [2*XLEN-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  always_comb begin
    signed_a_d = (bus.funct3 == FN_MULH) || (bus.funct3 == FN_MULHSU) ||
                 (bus.funct3 == FN_DIV)  || (bus.funct3 == FN_REM);
    signed_b_d = (bus.funct3 == FN_MULH) || (bus.funct3 == FN_DIV) ||
                 (bus.funct3 == FN_REM);
    neg_a_d    = signed_a_d && bus.op_a[XLEN-1];
    neg_b_d    = signed_b_d && bus.op_b[XLEN-1];
    a_mag_d    = neg_w(bus.op_a, neg_a_d);
    b_mag_d    = neg_w(bus.op_b, neg_b_d);
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic early_d;
  assign early_d = bus.funct3[2] ? (bus.op_b == '0) : ((bus.op_a == '0) || (bus.op_b == '0));
`endif

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div_i (fn_q[2]),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .m_i      (m_q),
    .hi_o     (hi_d),
    .lo_o     (lo_d)
  );

  // Division works on magnitudes; a zero divisor keeps the all-ones quotient unsigned.
  always_comb begin
    prod_d = neg_p({hi_q, lo_q}, neg_a_q ^ neg_b_q);
    res_d  = '0;
    case (fn_q)
      FN_MUL:                      res_d = prod_d[XLEN-1:0];
      FN_MULH, FN_MULHSU, FN_MULHU: res_d = prod_d[2*XLEN-1:XLEN];
      FN_DIV, FN_DIVU:             res_d = (m_q == '0) ? '1 : neg_w(lo_q, neg_a_q ^ neg_b_q);
      default:                     res_d = neg_w(hi_q, neg_a_q);
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      fn_q     <= FN_MUL;
      rd_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      m_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_en_q  <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (bus.start) begin
          fn_q    <= bus.funct3;
          rd_q    <= bus.rd_in;
          neg_a_q <= neg_a_d;
          neg_b_q <= neg_b_d;
          m_q     <= bus.funct3[2] ? b_mag_d : a_mag_d;
          lo_q    <= bus.funct3[2] ? a_mag_d : b_mag_d;
          hi_q    <= '0;
          count_q <= '0;
          busy_q  <= 1'b1;
          state_q <= ST_CALC;
`ifdef MULDIV_EARLY_OUT_EN
          if (early_d) begin
            hi_q    <= bus.funct3[2] ? a_mag_d : '0;
            lo_q    <= bus.funct3[2] ? '1 : '0;
            state_q <= ST_FIX;
          end
`endif
        end
        ST_CALC: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          count_q <= count_q + CW'(1);
          if (count_q == CW'(XLEN - 1)) state_q <= ST_FIX;
        end
        ST_FIX: begin
          result_q <= res_d;
          state_q  <= ST_DONE;
        end
        default: begin
          done_q  <= 1'b1;
          wr_en_q <= (rd_q != 5'd0);
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.wr_en  = wr_en_q;
  assign bus.rd_out = rd_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against an arithmetic RV32M reference model.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   dones  = 0;
  int   issued = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;
  exp_t exp_q[$];
  exp_t cur;

  muldiv_if #(.XLEN(32)) bus ();
  muldiv_unit #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (fn)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (fn[2] ? (b == 0) : (a == 0 || b == 0)) return 2;
`endif
    return 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  // Every cycle out of reset: a done pulse must match the oldest outstanding op.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.done) begin
        dones++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: done=1 with no operation outstanding");
        end else begin
          cur = exp_q.pop_front();
          if (bus.result !== cur.res) begin
            errors++;
            $display("FAIL result: got %h expected %h", bus.result, cur.res);
          end
          checks++;
          if (bus.rd_out !== cur.rd) begin
            errors++;
            $display("FAIL rd_out: got %0d expected %0d", bus.rd_out, cur.rd);
          end
          checks++;
          if (bus.wr_en !== (cur.rd != 0)) begin
            errors++;
            $display("FAIL wr_en: got %b expected %b (rd=%0d)", bus.wr_en, cur.rd != 0, cur.rd);
          end
          checks++;
          if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_at_done: got %b expected 0", bus.busy);
          end
        end
      end else begin
        checks++;
        if (bus.wr_en !== 1'b0) begin
          errors++;
          $display("FAIL wr_en_no_done: got %b expected 0", bus.wr_en);
        end
      end
    end
  end

  task automatic run_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit poke);
    int   n;
    int   want;
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = fn; bus.op_a = a; bus.op_b = b; bus.rd_in = rd;
    @(posedge clk);
    e.res = model(fn, a, b);
    e.rd  = rd;
    exp_q.push_back(e);
    issued++;
    want = exp_lat(fn, a, b);
    #1;
    bus.start = 1'b0;
    bus.op_a = $urandom(); bus.op_b = $urandom();
    bus.funct3 = 3'($urandom()); bus.rd_in = 5'($urandom());
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      bus.start = poke && (n == 10);
    end while (!bus.done && n < 100);
    bus.start = 1'b0;
    checks++;
    if (!bus.done || n != want) begin
      errors++;
      $display("FAIL latency: fn=%0d done after %0d edges (done=%b) expected %0d", fn, n, bus.done, want);
    end
  endtask

  task automatic run_dir(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] lit);
    run_op(fn, a, b, rd, 1'b0);
    checks++;
    if (bus.result !== lit) begin
      errors++;
      $display("FAIL literal fn=%0d a=%h b=%h: got %h expected %h", fn, a, b, bus.result, lit);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.funct3 = 3'd0; bus.op_a = '0; bus.op_b = '0; bus.rd_in = '0;
    #2 rst = 1'b0;
    #20;
    chk("reset_busy",   32'(bus.busy),   32'h0);
    chk("reset_done",   32'(bus.done),   32'h0);
    chk("reset_wr_en",  32'(bus.wr_en),  32'h0);
    chk("reset_rd_out", 32'(bus.rd_out), 32'h0);
    chk("reset_result", bus.result,      32'h0);
    @(negedge clk);
    rst = 1'b1;

    run_dir(3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB);
    run_dir(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE);
    run_dir(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'h00000000);
    run_dir(3'd2, 32'hFFFFFFFF, 32'h00000002, 5'd3,  32'hFFFFFFFF);
    run_dir(3'd4, 32'hFFFFFFF9, 32'h00000002, 5'd4,  32'hFFFFFFFD);
    run_dir(3'd6, 32'hFFFFFFF9, 32'h00000002, 5'd6,  32'hFFFFFFFF);
    run_dir(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd7,  32'h80000000);
    run_dir(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd8,  32'h00000000);
    run_dir(3'd0, 32'd0,        32'd12345,    5'd0,  32'h00000000);
    run_dir(3'd5, 32'h00001234, 32'h00000000, 5'd10, 32'hFFFFFFFF);
    run_dir(3'd4, 32'hFFFFFFF0, 32'h00000000, 5'd12, 32'hFFFFFFFF);
    run_dir(3'd6, 32'hFFFFFFF0, 32'h00000000, 5'd13, 32'hFFFFFFF0);

    // A second start mid-operation must be ignored.
    run_op(3'd0, 32'd1000, 32'd3000, 5'd11, 1'b1);
    chk("poke_result", bus.result, 32'd3000000);
    run_dir(3'd7, 32'd5, 32'd0, 5'd9, 32'h00000005);

    // Asynchronous reset mid-iteration aborts the op.
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'd3; bus.op_b = 32'd5; bus.rd_in = 5'd4;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy",   32'(bus.busy),   32'h0);
    chk("abort_done",   32'(bus.done),   32'h0);
    chk("abort_wr_en",  32'(bus.wr_en),  32'h0);
    chk("abort_result", bus.result,      32'h0);
    chk("abort_rd_out", 32'(bus.rd_out), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    run_dir(3'd4, 32'd100, 32'hFFFFFFF9, 5'd14, 32'hFFFFFFF2);

    for (int i = 0; i < 150; i++) begin
      run_op(3'($urandom()), pick(), pick(), 5'($urandom()), 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("done_count", 32'(dones), 32'(issued));
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
